// File: rtl/iob_regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package iob_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH      = 1 << ADDR_W_DEF;
    localparam int STRB_W     = DATA_W_DEF / 8;

    // Background clear sequencer states
    typedef enum logic {
        IDLE = 1'b0,
        CLR  = 1'b1
    } clr_state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int strb_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_regfile_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports, clear control.
// Latency: n/a (wires only); rdata is registered inside the register file.
// Backpressure: none; busy only reports that a clear is running and writes are dropped.
//
// Ports (all flattened, port p / read port r in slice [p*W +: W]):
//   we[N_W], waddr[N_W*ADDR_W], wstrb[N_W*DATA_W/8], wdata[N_W*DATA_W]
//   raddr[N_R*ADDR_W], rdata[N_R*DATA_W], clr, busy
interface iob_regfile_mp_if
    import iob_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_W    = 2,
    parameter int N_R    = 2
);

    logic [N_W-1:0]                  we;
    logic [N_W*ADDR_W-1:0]           waddr;
    logic [N_W*strb_of(DATA_W)-1:0]  wstrb;
    logic [N_W*DATA_W-1:0]           wdata;
    logic [N_R*ADDR_W-1:0]           raddr;
    logic [N_R*DATA_W-1:0]           rdata;
    logic                            clr;
    logic                            busy;

    modport master (
        output we, waddr, wstrb, wdata, raddr, clr,
        input  rdata, busy
    );

    modport slave (
        input  we, waddr, wstrb, wdata, raddr, clr,
        output rdata, busy
    );

endinterface

// File: rtl/iob_regfile_wmerge.sv
// Per-byte priority merge of all write ports targeting one entry; highest port index wins a byte.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_addr   entry index this merge serves
//   i_old    current stored word of that entry
//   i_we/i_waddr/i_wstrb/i_wdata  flattened write ports (already gated by the caller)
//   o_word   post-write word of the entry
module iob_regfile_wmerge
    import iob_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_W    = 2
) (
    input  logic [ADDR_W-1:0]                 i_addr,
    input  logic [DATA_W-1:0]                 i_old,
    input  logic [N_W-1:0]                    i_we,
    input  logic [N_W*ADDR_W-1:0]             i_waddr,
    input  logic [N_W*strb_of(DATA_W)-1:0]    i_wstrb,
    input  logic [N_W*DATA_W-1:0]             i_wdata,
    output logic [DATA_W-1:0]                 o_word
);

    localparam int L_STRB_W = strb_of(DATA_W);

    // Ports are applied in ascending order so a later (higher) port overwrites
    // any byte an earlier port already placed; untouched bytes keep i_old.
    always_comb begin
        o_word = i_old;
        for (int p = 0; p < N_W; p++) begin
            if (i_we[p] && (i_waddr[p*ADDR_W +: ADDR_W] == i_addr)) begin
                for (int b = 0; b < L_STRB_W; b++) begin
                    if (i_wstrb[p*L_STRB_W + b]) begin
                        o_word[b*8 +: 8] = i_wdata[p*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/iob_regfile_mp.sv
// Multi-port flop-based register file with byte strobes, optional read bypass and sequenced clear.
// Latency: writes land at the edge, reads are registered (1 cycle); a clear takes 2**ADDR_W cycles.
// Backpressure: none; while busy is high all writes are dropped, reads keep working.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active low
//   bus   iob_regfile_mp_if slave: we/waddr/wstrb/wdata, raddr -> rdata, clr -> busy
module iob_regfile_mp
    import iob_regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int N_W       = 2,
    parameter int N_R       = 2,
    parameter int RD_BYPASS = 1
) (
    input  logic               clk,
    input  logic               rst,
    iob_regfile_mp_if.slave    bus
);

    localparam int L_DEPTH = depth_of(ADDR_W);

    clr_state_t                          r_state;
    logic [ADDR_W:0]                     r_cnt;
    logic                                r_busy;
    logic [N_R-1:0][DATA_W-1:0]          r_rdata;

    logic [N_W-1:0]                      w_we;
    logic [L_DEPTH-1:0][DATA_W-1:0]      w_entry;
    logic [L_DEPTH-1:0][DATA_W-1:0]      w_merged;
    logic [L_DEPTH-1:0][DATA_W-1:0]      w_rd_src;

    // Writes are discarded, not deferred, while the clear sequencer owns the array.
    assign w_we = (r_state == IDLE) ? bus.we : '0;

    // ---------------------------------------------------------------
    // Storage: one register and one merge unit per entry
    // ---------------------------------------------------------------
    for (genvar e = 0; e < L_DEPTH; e++) begin : g_ent
        logic [DATA_W-1:0] r_word;

        iob_regfile_wmerge #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .N_W    (N_W)
        ) u_wmerge (
            .i_addr  (ADDR_W'(e)),
            .i_old   (r_word),
            .i_we    (w_we),
            .i_waddr (bus.waddr),
            .i_wstrb (bus.wstrb),
            .i_wdata (bus.wdata),
            .o_word  (w_merged[e])
        );

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_word <= '0;
            end else if ((r_state == CLR) && (r_cnt[ADDR_W-1:0] == ADDR_W'(e))) begin
                r_word <= '0;
            end else begin
                r_word <= w_merged[e];
            end
        end

        assign w_entry[e] = r_word;
    end

    // ---------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------
    // The bypass source is the write-merge result only: an entry being cleared
    // at this edge still reads its old value, it reads 0 from the next cycle.
    if (RD_BYPASS != 0) begin : g_byp
        assign w_rd_src = w_merged;
    end else begin : g_nobyp
        assign w_rd_src = w_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            for (int r = 0; r < N_R; r++) begin
                r_rdata[r] <= w_rd_src[bus.raddr[r*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign bus.rdata = r_rdata;

    // ---------------------------------------------------------------
    // Clear sequencer
    // ---------------------------------------------------------------
    // Counter is one bit wider than the address so the last-entry compare never
    // aliases with a wrapped value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clr) begin
                        r_state <= CLR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == (ADDR_W+1)'(L_DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;

endmodule

// File: tb/tb_iob_regfile_mp.sv
// Testbench for iob_regfile_mp: default config with and without bypass, plus a 4W/3R/16-bit sweep.
// Latency: n/a.
// Backpressure: n/a.
module tb_iob_regfile_mp;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration, bypass on (u0) and off (u1), driven identically
    iob_regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .N_W(2), .N_R(2)) if0 ();
    iob_regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .N_W(2), .N_R(2)) if1 ();
    // Sweep configuration
    iob_regfile_mp_if #(.DATA_W(16), .ADDR_W(3), .N_W(4), .N_R(3)) if2 ();

    iob_regfile_mp #(.DATA_W(32), .ADDR_W(4), .N_W(2), .N_R(2), .RD_BYPASS(1))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    iob_regfile_mp #(.DATA_W(32), .ADDR_W(4), .N_W(2), .N_R(2), .RD_BYPASS(0))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    iob_regfile_mp #(.DATA_W(16), .ADDR_W(3), .N_W(4), .N_R(3), .RD_BYPASS(1))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input logic [1:0] we,
                       input logic [3:0] wa0, input logic [3:0] wa1,
                       input logic [3:0] s0,  input logic [3:0] s1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] ra0, input logic [3:0] ra1,
                       input logic c);
        if0.we = we; if0.waddr = {wa1, wa0}; if0.wstrb = {s1, s0};
        if0.wdata = {d1, d0}; if0.raddr = {ra1, ra0}; if0.clr = c;
        if1.we = we; if1.waddr = {wa1, wa0}; if1.wstrb = {s1, s0};
        if1.wdata = {d1, d0}; if1.raddr = {ra1, ra0}; if1.clr = c;
    endtask

    task automatic idle(input logic [3:0] ra0, input logic [3:0] ra1);
        drv(2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 32'd0, 32'd0, ra0, ra1, 1'b0);
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < 16; i++) begin
            drv(2'b01, 4'(i), 4'd0, 4'hF, 4'h0, 32'(base + i), 32'd0, 4'd0, 4'd0, 1'b0);
            tick();
        end
    endtask

    task automatic expect_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            idle(4'(i), 4'(15 - i));
            tick();
            chk({tag, "_u0p0"}, if0.rdata[31:0],  32'd0);
            chk({tag, "_u0p1"}, if0.rdata[63:32], 32'd0);
            chk({tag, "_u1p0"}, if1.rdata[31:0],  32'd0);
        end
    endtask

    // Sweep reference model: plain array, writes applied port by port in index order
    logic [15:0] m2 [8];
    logic [15:0] nm  [8];
    logic [3:0]  we2;
    logic [11:0] wa2;
    logic [7:0]  st2;
    logic [63:0] wd2;
    logic [8:0]  ra2;
    int          n;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle(4'd0, 4'd0);
        if2.we = '0; if2.waddr = '0; if2.wstrb = '0; if2.wdata = '0;
        if2.raddr = '0; if2.clr = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        chk("rst_u0_rd0", if0.rdata[31:0],  32'd0);
        chk("rst_u0_rd1", if0.rdata[63:32], 32'd0);
        chk("rst_u0_busy", 32'(if0.busy), 32'd0);
        chk("rst_u1_rd0", if1.rdata[31:0],  32'd0);
        chk("rst_u2_rd",  32'(if2.rdata[15:0]), 32'd0);
        chk("rst_u2_busy", 32'(if2.busy), 32'd0);
        rst = 1'b1;

        // Fill 32+i through port 0, read back on both ports
        fill(32);
        for (int i = 0; i < 16; i++) begin
            idle(4'(i), 4'(15 - i));
            tick();
            chk("fill_u0p0", if0.rdata[31:0],  32'(32 + i));
            chk("fill_u0p1", if0.rdata[63:32], 32'(32 + 15 - i));
            chk("fill_u1p0", if1.rdata[31:0],  32'(32 + i));
        end

        // Same-address collision: port 1 owns bytes 0-1, port 0 keeps bytes 2-3
        drv(2'b11, 4'd3, 4'd3, 4'hF, 4'h3, 32'hAAAA_AAAA, 32'h5555_5555, 4'd0, 4'd0, 1'b0);
        tick();
        idle(4'd3, 4'd3);
        tick();
        chk("coll_u0p0", if0.rdata[31:0],  32'hAAAA_5555);
        chk("coll_u0p1", if0.rdata[63:32], 32'hAAAA_5555);
        chk("coll_u1p0", if1.rdata[31:0],  32'hAAAA_5555);

        // Partial strobes: byte 1 is written by nobody and keeps 0x00 of 0x00000024
        drv(2'b11, 4'd4, 4'd4, 4'hC, 4'h1, 32'h1122_3344, 32'h5566_7788, 4'd0, 4'd0, 1'b0);
        tick();
        idle(4'd4, 4'd0);
        tick();
        chk("merge_u0", if0.rdata[31:0], 32'h1122_0088);

        // Read during write on addr 5 (old value 0x25)
        drv(2'b01, 4'd5, 4'd0, 4'hF, 4'h0, 32'h0000_1234, 32'd0, 4'd5, 4'd0, 1'b0);
        tick();
        chk("byp_u0",     if0.rdata[31:0], 32'h0000_1234);
        chk("nobyp_u1",   if1.rdata[31:0], 32'h0000_0025);
        idle(4'd5, 4'd0);
        tick();
        chk("nobyp_u1_next", if1.rdata[31:0], 32'h0000_1234);

        // Bypass of a collision result on addr 6 (old value 0x26)
        drv(2'b11, 4'd6, 4'd6, 4'hF, 4'h3, 32'hAAAA_AAAA, 32'h5555_5555, 4'd0, 4'd6, 1'b0);
        tick();
        chk("byp_coll_u0", if0.rdata[63:32], 32'hAAAA_5555);
        chk("byp_coll_u1", if1.rdata[63:32], 32'h0000_0026);

        // Background clear
        fill(64);
        drv(2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1);
        tick();
        chk("clr_busy_start", 32'(if0.busy), 32'd1);
        n = 0;
        while (if0.busy && n < 40) begin
            n++;
            if (n == 6) begin
                chk("clr_rd_done", if0.rdata[31:0],  32'd0);
                chk("clr_rd_old",  if0.rdata[63:32], 32'd79);
            end
            if (n == 5)
                drv(2'b01, 4'd2, 4'd0, 4'hF, 4'h0, 32'hDEAD_BEEF, 32'd0, 4'd0, 4'd15, 1'b0);
            else if (n == 8)
                drv(2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1);
            else
                idle(4'd0, 4'd0);
            tick();
        end
        chk("clr_busy_cycles", 32'(n), 32'd16);
        chk("clr_u1_busy", 32'(if1.busy), 32'd0);
        expect_all_zero("clr_after");

        // Reset in the middle of a clear
        fill(64);
        drv(2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1);
        tick();
        idle(4'd0, 4'd0);
        for (int i = 0; i < 7; i++) tick();
        chk("midclr_busy_pre", 32'(if0.busy), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midclr_busy", 32'(if0.busy), 32'd0);
        expect_all_zero("midclr_after");
        drv(2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1);
        tick();
        chk("reclr_busy", 32'(if0.busy), 32'd1);
        idle(4'd0, 4'd0);
        n = 0;
        while (if0.busy && n < 40) begin
            n++;
            tick();
        end
        chk("reclr_busy_cycles", 32'(n), 32'd16);

        // Randomized sweep on the 4W/3R/16-bit instance (all entries zero after reset)
        for (int a = 0; a < 8; a++) m2[a] = 16'd0;
        for (int c = 0; c < 2000; c++) begin
            we2 = 4'($urandom);
            wa2 = 12'($urandom);
            st2 = 8'($urandom);
            wd2 = {$urandom, $urandom};
            ra2 = 9'($urandom);
            if2.we = we2; if2.waddr = wa2; if2.wstrb = st2;
            if2.wdata = wd2; if2.raddr = ra2; if2.clr = 1'b0;
            for (int a = 0; a < 8; a++) nm[a] = m2[a];
            for (int p = 0; p < 4; p++) begin
                if (we2[p]) begin
                    for (int b = 0; b < 2; b++) begin
                        if (st2[p*2 + b])
                            nm[wa2[p*3 +: 3]][b*8 +: 8] = wd2[p*16 + b*8 +: 8];
                    end
                end
            end
            tick();
            for (int r = 0; r < 3; r++)
                chk("sweep_rd", 32'(if2.rdata[r*16 +: 16]), 32'(nm[ra2[r*3 +: 3]]));
            for (int a = 0; a < 8; a++) m2[a] = nm[a];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
